// File: rtl/regfile_pkg.sv
// Shared register-file constants for the writeback arbiter and its users.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last winner.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               en,
  output logic [NUM_SRC-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = ptr;
    found        = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
    if (!en) begin
      grant_onehot = '0;
    end
  end

  // Pointer starts at the last slot so that slot 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(NUM_SRC - 1);
    end else if (en && (|req)) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_SRC writeback sources.
// Optional read bypass is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*5-1:0]       src_rd,
  input  logic [NUM_SRC*XLEN-1:0]    src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic                       flush,
  output logic                       wer,
  output logic [REG_ADDR_W-1:0]      rd,
  output logic [XLEN-1:0]            regdata,
  output logic [CNT_W-1:0]           contention
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]      rs1,
  input  logic [REG_ADDR_W-1:0]      rs2,
  input  logic [XLEN-1:0]            rv1_in,
  input  logic [XLEN-1:0]            rv2_in,
  output logic [XLEN-1:0]            rv1,
  output logic [XLEN-1:0]            rv2
`endif
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  arb_en;
  logic                  vld_p0;
  logic                  multi_req;
  logic [REG_ADDR_W-1:0] rd_arr   [NUM_SRC];
  logic [XLEN-1:0]       data_arr [NUM_SRC];
  logic [REG_ADDR_W-1:0] rd_p0;
  logic [XLEN-1:0]       data_p0;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign rd_arr[i]   = src_rd[i*REG_ADDR_W +: REG_ADDR_W];
    assign data_arr[i] = src_data[i*XLEN +: XLEN];
  end

  assign arb_en = !flush;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (src_valid),
    .en           (arb_en),
    .grant_onehot (grant),
    .grant_idx    (grant_idx)
  );

  assign src_ready = grant;
  assign vld_p0    = |grant;
  assign rd_p0     = rd_arr[grant_idx];
  assign data_p0   = data_arr[grant_idx];

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_req = |(src_valid & (src_valid - NUM_SRC'(1)));

  // ---- stage p0 -> p1: registered write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wer     <= 1'b0;
      rd      <= REG_ZERO;
      regdata <= '0;
    end else if (vld_p0) begin
      wer     <= !is_zero_reg(rd_p0);
      rd      <= rd_p0;
      regdata <= data_p0;
    end else begin
      wer     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= '0;
    end else if (arb_en && multi_req && (contention != {CNT_W{1'b1}})) begin
      contention <= contention + CNT_W'(1);
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rv1 = (wer && (rd == rs1) && !is_zero_reg(rs1)) ? regdata : rv1_in;
  assign rv2 = (wer && (rd == rs2) && !is_zero_reg(rs2)) ? regdata : rv2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, corner sequences, random vs model.
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    src_valid = '0;
  logic [14:0]   src_rd = '0;
  logic [95:0]   src_data = '0;
  logic [2:0]    src_ready;
  logic          flush = 1'b0;
  logic          wer;
  logic [4:0]    rd;
  logic [31:0]   regdata;
  logic [15:0]   contention;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]    rs1 = '0, rs2 = '0;
  logic [31:0]   rv1_in = '0, rv2_in = '0;
  logic [31:0]   rv1, rv2;
`endif

  regfile_wb_arbiter #(.NUM_SRC(3), .XLEN(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .flush      (flush),
    .wer        (wer),
    .rd         (rd),
    .regdata    (regdata),
    .contention (contention)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs1        (rs1),
    .rs2        (rs2),
    .rv1_in     (rv1_in),
    .rv2_in     (rv2_in),
    .rv1        (rv1),
    .rv2        (rv2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          ptr_m;
  logic        wer_m;
  logic [4:0]  rd_m;
  logic [31:0] data_m;
  int          cont_m;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] rds;
    logic        flush;
    logic [2:0]  ready;
    logic        wer;
    logic [4:0]  rd;
    logic [15:0] cont;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [2:0] v, input logic f);
    if (f) return -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr_m + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m  = N - 1;
    wer_m  = 1'b0;
    rd_m   = '0;
    data_m = '0;
    cont_m = 0;
  endtask

  task automatic drive(input logic [2:0] v, input logic [14:0] r, input logic [95:0] d, input logic f);
    src_valid = v;
    src_rd    = r;
    src_data  = d;
    flush     = f;
  endtask

  task automatic settle(input bit c);
    int g;
    logic [2:0] er;
    #1;
    g  = model_grant(src_valid, flush);
    er = (g < 0) ? 3'b000 : (3'b001 << g);
    if (c) chk("ready_model", {29'd0, src_ready}, {29'd0, er});
  endtask

  task automatic edge_step(input bit c);
    int g;
    g = model_grant(src_valid, flush);
    if (!flush && ($countones(src_valid) >= 2) && (cont_m < 65535)) cont_m++;
    if (g >= 0) begin
      rd_m   = src_rd[g*5 +: 5];
      data_m = src_data[g*32 +: 32];
      wer_m  = (rd_m != 5'd0);
      ptr_m  = g;
    end else begin
      wer_m  = 1'b0;
    end
    @(posedge clk);
    #1;
    if (c) begin
      chk("wer_model", {31'd0, wer}, {31'd0, wer_m});
      chk("rd_model", {27'd0, rd}, {27'd0, rd_m});
      chk("regdata_model", regdata, data_m);
      chk("contention_model", {16'd0, contention}, cont_m);
`ifdef REGFILE_WB_BYPASS_EN
      chk("rv1_model", rv1, (wer_m && rd_m == rs1 && rs1 != 0) ? data_m : rv1_in);
      chk("rv2_model", rv2, (wer_m && rd_m == rs2 && rs2 != 0) ? data_m : rv2_in);
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(3'b000, '0, '0, 1'b0);
    #3;
    chk("rst_wer", {31'd0, wer}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_regdata", regdata, 32'd0);
    chk("rst_contention", {16'd0, contention}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [14:0] RDS_123 = {5'd3, 5'd2, 5'd1};
  localparam logic [14:0] RDS_103 = {5'd3, 5'd0, 5'd1};
  localparam logic [95:0] TDATA   = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};

  initial begin
    // valid, rds, flush | ready, wer, rd, contention after the edge
    tbl[0]  = '{3'b111, RDS_123, 1'b0, 3'b001, 1'b1, 5'd1, 16'd1};
    tbl[1]  = '{3'b111, RDS_123, 1'b0, 3'b010, 1'b1, 5'd2, 16'd2};
    tbl[2]  = '{3'b111, RDS_123, 1'b0, 3'b100, 1'b1, 5'd3, 16'd3};
    tbl[3]  = '{3'b111, RDS_123, 1'b0, 3'b001, 1'b1, 5'd1, 16'd4};
    tbl[4]  = '{3'b111, RDS_123, 1'b0, 3'b010, 1'b1, 5'd2, 16'd5};
    tbl[5]  = '{3'b111, RDS_123, 1'b0, 3'b100, 1'b1, 5'd3, 16'd6};
    tbl[6]  = '{3'b010, RDS_103, 1'b0, 3'b010, 1'b0, 5'd0, 16'd6};
    tbl[7]  = '{3'b111, RDS_123, 1'b0, 3'b100, 1'b1, 5'd3, 16'd7};
    tbl[8]  = '{3'b101, RDS_123, 1'b1, 3'b000, 1'b0, 5'd3, 16'd7};
    tbl[9]  = '{3'b101, RDS_123, 1'b0, 3'b001, 1'b1, 5'd1, 16'd8};
    tbl[10] = '{3'b000, RDS_123, 1'b0, 3'b000, 1'b0, 5'd1, 16'd8};
    tbl[11] = '{3'b110, RDS_123, 1'b0, 3'b010, 1'b1, 5'd2, 16'd9};

    #1;
    do_reset();

    // Single write, one-cycle latency
    drive(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEAD_BEEF}, 1'b0);
    settle(1'b1);
    chk("t1_ready", {29'd0, src_ready}, 32'd1);
    edge_step(1'b1);
    chk("t1_wer", {31'd0, wer}, 32'd1);
    chk("t1_rd", {27'd0, rd}, 32'd5);
    chk("t1_regdata", regdata, 32'hDEAD_BEEF);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, tbl[i].rds, TDATA, tbl[i].flush);
      settle(1'b1);
      chk($sformatf("tbl%0d_ready", i), {29'd0, src_ready}, {29'd0, tbl[i].ready});
      edge_step(1'b1);
      chk($sformatf("tbl%0d_wer", i), {31'd0, wer}, {31'd0, tbl[i].wer});
      chk($sformatf("tbl%0d_rd", i), {27'd0, rd}, {27'd0, tbl[i].rd});
      chk($sformatf("tbl%0d_cont", i), {16'd0, contention}, {16'd0, tbl[i].cont});
    end

`ifdef REGFILE_WB_BYPASS_EN
    drive(3'b001, {10'd0, 5'd7}, {64'd0, 32'h0000_1234}, 1'b0);
    settle(1'b1);
    edge_step(1'b1);
    rs1 = 5'd7; rv1_in = 32'd0;
    rs2 = 5'd0; rv2_in = 32'h5555_5555;
    #1;
    chk("byp_rv1", rv1, 32'h0000_1234);
    chk("byp_rv2", rv2, 32'h5555_5555);
    drive(3'b000, '0, '0, 1'b0);
    settle(1'b1);
    edge_step(1'b1);
    chk("byp_rv1_after", rv1, 32'd0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [14:0] r;
      for (int s = 0; s < N; s++) r[s*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(3'($urandom), r, {$urandom, $urandom, $urandom}, ($urandom_range(0, 9) == 0));
`ifdef REGFILE_WB_BYPASS_EN
      rs1 = ($urandom_range(0, 1) == 0) ? rd_m : 5'($urandom);
      rs2 = 5'($urandom);
      rv1_in = $urandom;
      rv2_in = $urandom;
`endif
      settle(1'b1);
      edge_step(1'b1);
    end

    // Drive the counter to the brink of saturation, then over it
    drive(3'b111, RDS_123, TDATA, 1'b0);
    for (int i = 0; i < 70000 && cont_m < 16'hFFFE; i++) begin
      settle(1'b0);
      edge_step(1'b0);
    end
    chk("cont_prefill", {16'd0, contention}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      settle(1'b1);
      edge_step(1'b1);
    end
    chk("cont_saturated", {16'd0, contention}, 32'h0000_FFFF);

    // Asynchronous reset in the middle of a write
    drive(3'b001, {10'd0, 5'd9}, {64'd0, 32'h0BAD_F00D}, 1'b0);
    settle(1'b1);
    edge_step(1'b1);
    chk("mid_wer_before", {31'd0, wer}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wer", {31'd0, wer}, 32'd0);
    chk("mid_rst_rd", {27'd0, rd}, 32'd0);
    chk("mid_rst_cont", {16'd0, contention}, 32'd0);
    model_reset();
    drive(3'b000, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(3'b011, RDS_123, TDATA, 1'b0);
    settle(1'b1);
    chk("post_rst_ready", {29'd0, src_ready}, 32'd1);
    edge_step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
